// File: rtl/fir8_pkg.sv
// Shared definitions for the fir8 sample sequencer: sequencer states, bank geometry and
// a saturating-counter helper.
package fir8_pkg;

   localparam int unsigned NUM_TAPS = 9;
   localparam int unsigned COEFF_W  = 32;
   localparam int unsigned CNT_W    = 16;

   typedef enum logic [1:0] {
      StIdle,
      StFire,
      StSettle,
      StCapture
   } fir8_state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/fir8_coef_bank.sv
// Shadow/active coefficient bank: writes land in shadow, a swap strobe copies the whole set
// into active at once.
module fir8_coef_bank
   import fir8_pkg::*;
(
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         wr_en,
   input  logic [3:0]                   wr_addr,
   input  logic [COEFF_W-1:0]           wr_data,
   input  logic                         commit,
   input  logic                         swap,
   output logic                         busy,
   output logic [NUM_TAPS*COEFF_W-1:0]  active
);

   logic [COEFF_W-1:0] shadow_q [NUM_TAPS];
   logic [COEFF_W-1:0] shadow_d [NUM_TAPS];
   logic [COEFF_W-1:0] active_q [NUM_TAPS];
   logic               pending_q;

   // A write in the swap cycle is forwarded so it is part of the copied set.
   always_comb begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
         shadow_d[k] = shadow_q[k];
         if (wr_en && (wr_addr == 4'(k))) shadow_d[k] = wr_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            shadow_q[k] <= '0;
            active_q[k] <= '0;
         end
         pending_q <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            shadow_q[k] <= shadow_d[k];
            if (swap) active_q[k] <= shadow_d[k];
         end
         // A commit coinciding with the swap re-arms for another copy.
         pending_q <= commit | (pending_q & ~swap);
      end
   end

   always_comb begin
      active = '0;
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
         active[k*COEFF_W +: COEFF_W] = active_q[k];
      end
   end

   assign busy = pending_q;

endmodule

// File: rtl/fir8_ctrl.sv
// Sample-rate sequencer for the 8th-order FIR: prescaler, input/output handshakes,
// fault counters and atomic coefficient updates on a sample boundary.
module fir8_ctrl
   import fir8_pkg::*;
#(
   parameter int unsigned pw_io_width = 12,
   parameter int unsigned pw_settle   = 3
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         enable,
   input  logic [15:0]                  div,
   input  logic                         coef_wr_en,
   input  logic [3:0]                   coef_wr_addr,
   input  logic [COEFF_W-1:0]           coef_wr_data,
   input  logic                         coef_commit,
   output logic                         coef_busy,
   input  logic [pw_io_width-1:0]       s_data,
   input  logic                         s_valid,
   output logic                         s_ready,
   output logic                         fir_ce,
   output logic [pw_io_width-1:0]       fir_in,
   output logic [NUM_TAPS*COEFF_W-1:0]  fir_coeff,
   input  logic [pw_io_width-1:0]       fir_out,
   output logic [pw_io_width-1:0]       m_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   input  logic                         clr_cnt,
   output logic [CNT_W-1:0]             underrun_cnt,
   output logic [CNT_W-1:0]             overrun_cnt
);

   localparam logic [15:0] DivMin     = 16'(pw_settle + 2);
   localparam logic [3:0]  SettleLast = 4'(pw_settle - 1);

   fir8_state_e state_q;
   logic [3:0]  settle_q;
   logic [15:0] presc_q;
   logic [15:0] div_eff;
   logic        en_q;
   logic        tick_q;
   logic        run;
   logic        take_tick;
   logic        underrun_inc;
   logic        overrun_inc;
   logic        swap;

   // The period must leave room for a full FIRE/SETTLE/CAPTURE pass before the next tick.
   assign div_eff = (div > DivMin) ? div : DivMin;
   assign run     = enable & en_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         en_q    <= 1'b0;
         tick_q  <= 1'b0;
         presc_q <= '0;
      end else begin
         en_q   <= enable;
         tick_q <= run && (presc_q >= div_eff);
         if (!run || (presc_q >= div_eff)) presc_q <= '0;
         else                              presc_q <= presc_q + 16'd1;
      end
   end

   assign take_tick    = (state_q == StIdle) && tick_q;
   assign s_ready      = take_tick && s_valid;
   assign underrun_inc = take_tick && !s_valid;
   assign overrun_inc  = (state_q == StCapture) && m_valid && !m_ready;
   assign swap         = (state_q == StIdle) && coef_busy;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StIdle;
         settle_q     <= '0;
         fir_ce       <= 1'b0;
         fir_in       <= '0;
         m_data       <= '0;
         m_valid      <= 1'b0;
         underrun_cnt <= '0;
         overrun_cnt  <= '0;
      end else begin
         fir_ce <= 1'b0;
         if (m_valid && m_ready) m_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (tick_q) begin
                  if (s_valid) fir_in <= s_data;
                  fir_ce  <= 1'b1;
                  state_q <= StFire;
               end
            end
            StFire: begin
               settle_q <= '0;
               state_q  <= StSettle;
            end
            StSettle: begin
               if (settle_q == SettleLast) state_q <= StCapture;
               else                        settle_q <= settle_q + 4'd1;
            end
            StCapture: begin
               m_data  <= fir_out;
               m_valid <= 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
         if (clr_cnt) begin
            underrun_cnt <= '0;
            overrun_cnt  <= '0;
         end else begin
            if (underrun_inc) underrun_cnt <= sat_inc(underrun_cnt);
            if (overrun_inc)  overrun_cnt  <= sat_inc(overrun_cnt);
         end
      end
   end

   fir8_coef_bank u_coef_bank (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (coef_wr_en),
      .wr_addr (coef_wr_addr),
      .wr_data (coef_wr_data),
      .commit  (coef_commit),
      .swap    (swap),
      .busy    (coef_busy),
      .active  (fir_coeff)
   );

endmodule

// File: tb/tb_fir8_ctrl.sv
// Directed bench for fir8_ctrl; a stand-in FIR latches fir_in on fir_ce and returns it plus one.
module tb_fir8_ctrl;
   import fir8_pkg::*;

   localparam int unsigned IoW = 12;

   logic                        clk          = 1'b0;
   logic                        rstn         = 1'b0;
   logic                        enable       = 1'b0;
   logic [15:0]                 div          = 16'd9;
   logic                        coef_wr_en   = 1'b0;
   logic [3:0]                  coef_wr_addr = '0;
   logic [31:0]                 coef_wr_data = '0;
   logic                        coef_commit  = 1'b0;
   logic                        coef_busy;
   logic [IoW-1:0]              s_data       = 12'h123;
   logic                        s_valid      = 1'b1;
   logic                        s_ready;
   logic                        fir_ce;
   logic [IoW-1:0]              fir_in;
   logic [NUM_TAPS*COEFF_W-1:0] fir_coeff;
   logic [IoW-1:0]              fir_out;
   logic [IoW-1:0]              m_data;
   logic                        m_valid;
   logic                        m_ready      = 1'b1;
   logic                        clr_cnt      = 1'b0;
   logic [15:0]                 underrun_cnt;
   logic [15:0]                 overrun_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   logic [NUM_TAPS*COEFF_W-1:0] exp_coef = '0;
   logic [IoW-1:0]              fir_q;

   always #5 clk = ~clk;

   always @(posedge clk or negedge rstn) begin
      if (!rstn)       fir_q <= '0;
      else if (fir_ce) fir_q <= fir_in;
   end
   assign fir_out = fir_q + 12'd1;

   fir8_ctrl #(.pw_io_width(12), .pw_settle(3)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .enable       (enable),
      .div          (div),
      .coef_wr_en   (coef_wr_en),
      .coef_wr_addr (coef_wr_addr),
      .coef_wr_data (coef_wr_data),
      .coef_commit  (coef_commit),
      .coef_busy    (coef_busy),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .fir_ce       (fir_ce),
      .fir_in       (fir_in),
      .fir_coeff    (fir_coeff),
      .fir_out      (fir_out),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .clr_cnt      (clr_cnt),
      .underrun_cnt (underrun_cnt),
      .overrun_cnt  (overrun_cnt)
   );

   task automatic wait_ce(input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (fir_ce !== 1'b1 && n < limit);
      if (fir_ce !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_ce: no fir_ce in %0d cycles, required a pulse", limit);
      end
   endtask

   // Release reset while clk is low; div=9 gives div_eff+2 = 11 edges to the first fir_ce.
   task automatic release_and_time_first_ce();
      int n;
      rstn = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (fir_ce !== 1'b1 && n < 60);
      n_checks++;
      if (n - 1 != 11) begin
         n_fail++;
         $display("FAIL first_ce: got %0d edges after release, required 11", n - 1);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({s_ready, fir_ce, m_valid, coef_busy} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b required 0000", {s_ready, fir_ce, m_valid, coef_busy});
      end
      n_checks++;
      if ({fir_in, m_data} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h required 000000", {fir_in, m_data});
      end
      n_checks++;
      if ({underrun_cnt, overrun_cnt} !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_cnt: got %h required 00000000", {underrun_cnt, overrun_cnt});
      end
      n_checks++;
      if (fir_coeff !== '0) begin
         n_fail++;
         $display("FAIL reset_coeff: got %h required 0", fir_coeff);
      end
   endtask

   task automatic test_startup();
      enable = 1'b1;
      div    = 16'd9;
      #2;
      release_and_time_first_ce();
   endtask

   task automatic test_period();
      logic [IoW-1:0] smp [4] = '{12'h123, 12'h0A5, 12'hFFF, 12'h800};
      logic [IoW-1:0] res [3] = '{12'h124, 12'h0A6, 12'h000};
      int n;
      int sr_at;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (fir_in !== smp[i]) begin
            n_fail++;
            $display("FAIL period_fir_in: got %h required %h", fir_in, smp[i]);
         end
         s_data = smp[i+1];
         if (i == 0) begin
            coef_wr_en   = 1'b1;
            coef_wr_addr = 4'd0;
            coef_wr_data = 32'h7FFF_FFFF;
            @(negedge clk);
            coef_wr_en  = 1'b0;
            coef_commit = 1'b1;
            @(negedge clk);
            coef_commit = 1'b0;
            repeat (3) @(negedge clk);
         end else begin
            repeat (5) @(negedge clk);
         end
         n_checks++;
         if (m_valid !== 1'b1 || m_data !== res[i]) begin
            n_fail++;
            $display("FAIL period_m_data: got valid=%b data=%h required valid=1 data=%h",
                     m_valid, m_data, res[i]);
         end
         n = 5;
         sr_at = -1;
         do begin
            @(negedge clk);
            n++;
            if (s_ready === 1'b1) sr_at = n;
         end while (fir_ce !== 1'b1 && n < 40);
         n_checks++;
         if (n != 10 || sr_at != 9) begin
            n_fail++;
            $display("FAIL period_spacing: got ce at %0d s_ready at %0d required 10 and 9", n, sr_at);
         end
      end
      n_checks++;
      if (fir_in !== smp[3]) begin
         n_fail++;
         $display("FAIL period_last_in: got %h required %h", fir_in, smp[3]);
      end
      exp_coef[31:0] = 32'h7FFF_FFFF;
      n_checks++;
      if (fir_coeff !== exp_coef) begin
         n_fail++;
         $display("FAIL coef0: got %h required %h", fir_coeff, exp_coef);
      end
   endtask

   task automatic test_clamp();
      int n;
      div = 16'd1;
      wait_ce(40, n);
      for (int i = 0; i < 3; i++) begin
         wait_ce(40, n);
         n_checks++;
         if (n != 6) begin
            n_fail++;
            $display("FAIL clamp_period: got %0d cycles required 6", n);
         end
      end
   endtask

   task automatic test_underrun();
      int n;
      s_valid = 1'b0;
      s_data  = 12'h3C3;
      for (int i = 0; i < 3; i++) begin
         wait_ce(20, n);
         n_checks++;
         if (n != 6 || fir_in !== 12'h800) begin
            n_fail++;
            $display("FAIL underrun_tick: got period %0d fir_in %h required 6 and 800", n, fir_in);
         end
      end
      n_checks++;
      if (underrun_cnt !== 16'd3) begin
         n_fail++;
         $display("FAIL underrun_cnt: got %0d required 3", underrun_cnt);
      end
      // clr_cnt lands exactly on the next starved tick.
      repeat (5) @(negedge clk);
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      n_checks++;
      if (fir_ce !== 1'b1 || underrun_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL clr_priority: got ce=%b underrun=%0d required ce=1 underrun=0",
                  fir_ce, underrun_cnt);
      end
      s_valid = 1'b1;
   endtask

   task automatic test_overrun();
      logic [IoW-1:0] ov [4] = '{12'h111, 12'h222, 12'h333, 12'h444};
      int n;
      div = 16'd9;
      wait_ce(20, n);
      m_ready = 1'b0;
      for (int j = 0; j < 3; j++) begin
         s_data = ov[j];
         wait_ce(20, n);
      end
      s_data = ov[3];
      repeat (5) @(negedge clk);
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 12'h334 || overrun_cnt !== 16'd3) begin
         n_fail++;
         $display("FAIL overrun: got valid=%b data=%h cnt=%0d required valid=1 data=334 cnt=3",
                  m_valid, m_data, overrun_cnt);
      end
      m_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_drain: got m_valid=%b required 0", m_valid);
      end
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      n_checks++;
      if (overrun_cnt !== 16'd0 || underrun_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL clr_cnt: got overrun=%0d underrun=%0d required 0 and 0",
                  overrun_cnt, underrun_cnt);
      end
   endtask

   task automatic test_coef();
      int n;
      wait_ce(20, n);
      coef_wr_en   = 1'b1;
      coef_wr_addr = 4'd4;
      coef_wr_data = 32'h4000_0000;
      @(negedge clk);
      coef_wr_en  = 1'b0;
      coef_commit = 1'b1;
      @(negedge clk);
      coef_commit = 1'b0;
      n_checks++;
      if (coef_busy !== 1'b1 || fir_coeff[159:128] !== 32'h0) begin
         n_fail++;
         $display("FAIL coef_settle: got busy=%b slot4=%h required busy=1 slot4=0",
                  coef_busy, fir_coeff[159:128]);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (coef_busy !== 1'b1 || fir_coeff[159:128] !== 32'h0) begin
         n_fail++;
         $display("FAIL coef_idle: got busy=%b slot4=%h required busy=1 slot4=0",
                  coef_busy, fir_coeff[159:128]);
      end
      @(negedge clk);
      exp_coef[159:128] = 32'h4000_0000;
      n_checks++;
      if (coef_busy !== 1'b0 || fir_coeff !== exp_coef) begin
         n_fail++;
         $display("FAIL coef_swap: got busy=%b coeff=%h required busy=0 coeff=%h",
                  coef_busy, fir_coeff, exp_coef);
      end
      coef_wr_en   = 1'b1;
      coef_wr_addr = 4'd2;
      coef_wr_data = 32'h1234_5678;
      coef_commit  = 1'b1;
      @(negedge clk);
      coef_wr_addr = 4'd3;
      coef_wr_data = 32'h0BAD_F00D;
      @(negedge clk);
      coef_wr_en  = 1'b0;
      coef_commit = 1'b0;
      exp_coef[95:64]  = 32'h1234_5678;
      exp_coef[127:96] = 32'h0BAD_F00D;
      n_checks++;
      if (coef_busy !== 1'b1 || fir_coeff !== exp_coef) begin
         n_fail++;
         $display("FAIL coef_same_cycle: got busy=%b coeff=%h required busy=1 coeff=%h",
                  coef_busy, fir_coeff, exp_coef);
      end
      @(negedge clk);
      n_checks++;
      if (coef_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL coef_rearm: got busy=%b required 0", coef_busy);
      end
      coef_wr_en   = 1'b1;
      coef_wr_addr = 4'd9;
      coef_wr_data = 32'hFFFF_FFFF;
      coef_commit  = 1'b1;
      @(negedge clk);
      coef_wr_en  = 1'b0;
      coef_commit = 1'b0;
      repeat (12) @(negedge clk);
      n_checks++;
      if (coef_busy !== 1'b0 || fir_coeff !== exp_coef) begin
         n_fail++;
         $display("FAIL coef_bad_addr: got busy=%b coeff=%h required busy=0 coeff=%h",
                  coef_busy, fir_coeff, exp_coef);
      end
   endtask

   task automatic test_enable_stop();
      int n;
      int ces;
      wait_ce(20, n);
      enable = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 12'h445) begin
         n_fail++;
         $display("FAIL stop_finish: got valid=%b data=%h required valid=1 data=445",
                  m_valid, m_data);
      end
      ces = 0;
      repeat (40) begin
         @(negedge clk);
         if (fir_ce === 1'b1) ces++;
      end
      n_checks++;
      if (ces != 0) begin
         n_fail++;
         $display("FAIL stop_frozen: got %0d fir_ce pulses required 0", ces);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      enable  = 1'b1;
      m_ready = 1'b0;
      s_data  = 12'h5A5;
      wait_ce(40, n);
      wait_ce(20, n);
      repeat (2) @(negedge clk);
      n_checks++;
      if (m_valid !== 1'b1 || fir_coeff !== exp_coef) begin
         n_fail++;
         $display("FAIL pre_reset: got valid=%b coeff=%h required valid=1 coeff=%h",
                  m_valid, fir_coeff, exp_coef);
      end
      #2;
      rstn = 1'b0;
      #1;
      n_checks++;
      if ({fir_ce, m_valid, s_ready, coef_busy} !== 4'b0 || {fir_in, m_data} !== 24'h0) begin
         n_fail++;
         $display("FAIL async_reset: got flags=%b data=%h required 0000 and 000000",
                  {fir_ce, m_valid, s_ready, coef_busy}, {fir_in, m_data});
      end
      n_checks++;
      if (fir_coeff !== '0 || {underrun_cnt, overrun_cnt} !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset_bank: got coeff=%h cnt=%h required 0",
                  fir_coeff, {underrun_cnt, overrun_cnt});
      end
      m_ready = 1'b1;
      #1;
      release_and_time_first_ce();
   endtask

   initial begin
      test_reset();
      test_startup();
      test_period();
      test_clamp();
      test_underrun();
      test_overrun();
      test_coef();
      test_enable_stop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
